// File: rtl/clk_pulse_pkg.sv
// Shared types and constants for the programmable pulse scheduler.
// Holds the FSM encoding, reset defaults and the config legality rule.
package clk_pulse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int   DEF_CNT_W  = 12;
   localparam int   DEF_PERIOD = 2;
   localparam int   DEF_HIGH   = 1;
   localparam logic DEF_INIT   = 1'b0;

   // A period needs at least two cycles; high time may not exceed it.
   function automatic logic cfg_legal(
      input logic [31:0] period,
      input logic [31:0] high
   );
      return (period >= 32'd2) && (high <= period);
   endfunction

endpackage

// File: rtl/clk_pulse_cfg.sv
// Pending configuration holder for clk_pulse_ctrl.
// Checks each write, buffers the last legal one, and pulses ack/err.
module clk_pulse_cfg
   import clk_pulse_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_wr,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic             apply_i,
   output logic             pend_o,
   output logic [CNT_W-1:0] pend_period_o,
   output logic [CNT_W-1:0] pend_high_o,
   output logic             cfg_ack,
   output logic             cfg_err
);

   logic             legal;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] pper_q, pper_d;
   logic [CNT_W-1:0] phigh_q, phigh_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;

   // Next pending state; a write in the apply cycle survives for the next boundary.
   always_comb begin
      legal   = cfg_legal(32'(cfg_period), 32'(cfg_high));
      pend_d  = pend_q;
      pper_d  = pper_q;
      phigh_d = phigh_q;
      if (apply_i) begin
         pend_d = 1'b0;
      end
      if (cfg_wr && legal) begin
         pend_d  = 1'b1;
         pper_d  = cfg_period;
         phigh_d = cfg_high;
      end
      ack_d = cfg_wr && legal;
      err_d = cfg_wr && !legal;
   end

   // Pending registers and one-cycle response strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q  <= 1'b0;
         pper_q  <= CNT_W'(DEF_PERIOD);
         phigh_q <= CNT_W'(DEF_HIGH);
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         pper_q  <= pper_d;
         phigh_q <= phigh_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign pend_o        = pend_q;
   assign pend_period_o = pper_q;
   assign pend_high_o   = phigh_q;
   assign cfg_ack       = ack_q;
   assign cfg_err       = err_q;

endmodule

// File: rtl/clk_pulse_ctrl.sv
// Programmable divided-clock / enable generator with glitch-free updates.
// Config changes take effect only at period boundaries; outputs are registered.
module clk_pulse_ctrl
   import clk_pulse_pkg::*;
#(
   parameter int   CNT_W      = DEF_CNT_W,
   parameter int   DEF_PERIOD = clk_pulse_pkg::DEF_PERIOD,
   parameter int   DEF_HIGH   = clk_pulse_pkg::DEF_HIGH,
   parameter logic INIT_VAL   = DEF_INIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             cfg_wr,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_high,
   output logic             cfg_ack,
   output logic             cfg_err,
   output logic             pulse_o,
   output logic             tick_o,
   output logic             run_o,
   output logic [CNT_W-1:0] per_cnt_o
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic [CNT_W-1:0] aper_q, aper_d;
   logic [CNT_W-1:0] ahigh_q, ahigh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;
   logic             tick_q, tick_d;
   logic             run_q, run_d;

   logic             period_end;
   logic             apply;
   logic             pend;
   logic [CNT_W-1:0] pend_period;
   logic [CNT_W-1:0] pend_high;

   assign period_end = (state_q != ST_IDLE) &&
                       (phase_q == aper_q - CNT_W'(1));
   assign apply      = period_end || ((state_q == ST_IDLE) && en_i);

   clk_pulse_cfg #(
      .CNT_W (CNT_W)
   ) u_cfg (
      .clk           (clk),
      .rst           (rst),
      .cfg_wr        (cfg_wr),
      .cfg_period    (cfg_period),
      .cfg_high      (cfg_high),
      .apply_i       (apply),
      .pend_o        (pend),
      .pend_period_o (pend_period),
      .pend_high_o   (pend_high),
      .cfg_ack       (cfg_ack),
      .cfg_err       (cfg_err)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: en_i keeps or resumes running; drop it to drain the period.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (en_i) state_d = ST_RUN;
         end
         ST_RUN, ST_DRAIN: begin
            if (en_i)            state_d = ST_RUN;
            else if (period_end) state_d = ST_IDLE;
            else                 state_d = ST_DRAIN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Phase, period counter and active config for the coming cycle.
   always_comb begin
      if (state_d == ST_IDLE || state_q == ST_IDLE || period_end) begin
         phase_d = '0;
      end else begin
         phase_d = phase_q + CNT_W'(1);
      end
      cnt_d   = period_end ? cnt_q + CNT_W'(1) : cnt_q;
      aper_d  = aper_q;
      ahigh_d = ahigh_q;
      if (apply && pend) begin
         aper_d  = pend_period;
         ahigh_d = pend_high;
      end
   end

   // Output decode from next state so outputs line up with the phase.
   always_comb begin
      run_d   = (state_d != ST_IDLE);
      pulse_d = run_d ? (phase_d < ahigh_d) : INIT_VAL;
      tick_d  = run_d && (phase_d == '0);
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= '0;
         aper_q  <= CNT_W'(DEF_PERIOD);
         ahigh_q <= CNT_W'(DEF_HIGH);
         cnt_q   <= '0;
         pulse_q <= INIT_VAL;
         tick_q  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         aper_q  <= aper_d;
         ahigh_q <= ahigh_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         tick_q  <= tick_d;
         run_q   <= run_d;
      end
   end

   assign pulse_o   = pulse_q;
   assign tick_o    = tick_q;
   assign run_o     = run_q;
   assign per_cnt_o = cnt_q;

endmodule

// File: tb/tb_clk_pulse_ctrl.sv
// Self-checking bench for clk_pulse_ctrl.
// Behavioural model feeds a scoreboard queue; hand sequences check corners.
module tb_clk_pulse_ctrl;

   localparam int W = 12;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en_i = 1'b0;
   logic         cfg_wr = 1'b0;
   logic [W-1:0] cfg_period = '0;
   logic [W-1:0] cfg_high = '0;
   logic         cfg_ack, cfg_err, pulse_o, tick_o, run_o;
   logic [W-1:0] per_cnt_o;

   always #5 clk = ~clk;

   clk_pulse_ctrl #(
      .CNT_W      (W),
      .DEF_PERIOD (2),
      .DEF_HIGH   (1),
      .INIT_VAL   (1'b0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en_i),
      .cfg_wr     (cfg_wr),
      .cfg_period (cfg_period),
      .cfg_high   (cfg_high),
      .cfg_ack    (cfg_ack),
      .cfg_err    (cfg_err),
      .pulse_o    (pulse_o),
      .tick_o     (tick_o),
      .run_o      (run_o),
      .per_cnt_o  (per_cnt_o)
   );

   typedef struct packed {
      logic         pulse;
      logic         tick;
      logic         run;
      logic         ack;
      logic         err;
      logic [W-1:0] cnt;
   } exp_t;

   typedef struct {
      bit wr;
      int p;
      int h;
      bit ack;
      bit err;
   } vec_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model state: st 0=idle 1=run 2=drain
   int m_st, m_ph, m_per, m_high, m_pp, m_phh, m_cnt;
   bit m_pend;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      failures++;
      $display("FAIL %s timeout", nm);
   endtask

   task automatic model(input bit r, input bit e, input bit w,
                        input int p, input int h, output exp_t x);
      bit legal, endp;
      int nst, nph;
      if (r) begin
         m_st = 0; m_ph = 0; m_per = 2; m_high = 1;
         m_pend = 0; m_cnt = 0;
         x = '0;
      end else begin
         legal = w && (p >= 2) && (h <= p);
         endp  = (m_st != 0) && (m_ph == m_per - 1);
         if (m_st == 0)  nst = e ? 1 : 0;
         else if (e)     nst = 1;
         else if (endp)  nst = 0;
         else            nst = 2;
         nph = (nst == 0 || endp || m_st == 0) ? 0 : m_ph + 1;
         if (endp) m_cnt = (m_cnt + 1) % 4096;
         if ((endp || (m_st == 0 && e)) && m_pend) begin
            m_per = m_pp; m_high = m_phh; m_pend = 0;
         end
         if (legal) begin
            m_pp = p; m_phh = h; m_pend = 1;
         end
         m_st = nst;
         m_ph = nph;
         x.pulse = (m_st != 0) ? (m_ph < m_high) : 1'b0;
         x.tick  = (m_st != 0) && (m_ph == 0);
         x.run   = (m_st != 0);
         x.ack   = legal;
         x.err   = w && !legal;
         x.cnt   = W'(m_cnt);
      end
   endtask

   // Drive one cycle of inputs, push expectation, compare after the edge.
   task automatic step(input bit r, input bit e, input bit w,
                       input int p, input int h);
      exp_t x, got;
      rst = r; en_i = e; cfg_wr = w;
      cfg_period = W'(p); cfg_high = W'(h);
      model(r, e, w, p, h, x);
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      x = sb_q.pop_front();
      got = {pulse_o, tick_o, run_o, cfg_ack, cfg_err, per_cnt_o};
      checks++;
      if (got !== x) begin
         failures++;
         $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, got, x);
      end
   endtask

   task automatic run1();
      step(0, 1, 0, 0, 0);
   endtask

   vec_t vecs[6];
   bit   pat_p2[7];
   bit   pat_t2[7];
   bit   pat1[4];
   int   c0, n, hi;
   bit   hit;

   initial begin
      vecs[0] = '{wr:1, p:1,  h:0, ack:0, err:1};
      vecs[1] = '{wr:1, p:4,  h:5, ack:0, err:1};
      vecs[2] = '{wr:1, p:0,  h:0, ack:0, err:1};
      vecs[3] = '{wr:0, p:1,  h:0, ack:0, err:0};
      vecs[4] = '{wr:1, p:2,  h:3, ack:0, err:1};
      vecs[5] = '{wr:1, p:5,  h:2, ack:1, err:0};
      pat1    = '{1, 0, 1, 0};
      pat_p2  = '{0, 1, 1, 0, 0, 0, 1};
      pat_t2  = '{0, 1, 0, 0, 0, 0, 1};

      // 1: reset values, then default 1,0,1,0 with ticks every 2
      step(1, 0, 0, 0, 0);
      chk("rst_pulse", pulse_o, 0);
      chk("rst_tick", tick_o, 0);
      chk("rst_run", run_o, 0);
      chk("rst_cnt", per_cnt_o, 0);
      for (int i = 0; i < 4; i++) begin
         run1();
         chk("t1_pulse", pulse_o, pat1[i]);
         chk("t1_tick", tick_o, pat1[i]);
      end

      // 2: write (5,2) in a period-end cycle; applied one boundary later
      step(0, 1, 1, 5, 2);
      chk("t2_ack", cfg_ack, 1);
      chk("t2_first", pulse_o, 1);
      for (int i = 0; i < 7; i++) begin
         run1();
         chk("t2_pulse", pulse_o, pat_p2[i]);
         chk("t2_tick", tick_o, pat_t2[i]);
      end

      // 3: illegal writes rejected, active config unchanged
      foreach (vecs[i]) begin
         step(0, 1, vecs[i].wr, vecs[i].p, vecs[i].h);
         chk("t3_ack", cfg_ack, vecs[i].ack);
         chk("t3_err", cfg_err, vecs[i].err);
      end
      n = 0;
      for (int i = 0; i < 10; i++) begin
         run1();
         if (tick_o === 1'b1) n++;
      end
      chk("t3_ticks10", n, 2);

      // 4: period 6, drop en_i at phase 2
      step(0, 1, 1, 6, 3);
      hit = 0;
      for (int i = 0; i < 30 && !hit; i++) begin
         run1();
         if (m_per == 6 && m_ph == 2) hit = 1;
      end
      if (!hit) timeout("t4_align");
      c0 = m_cnt;
      step(0, 0, 0, 0, 0);
      chk("t4_run3", run_o, 1);
      step(0, 0, 0, 0, 0);
      chk("t4_run4", run_o, 1);
      step(0, 0, 0, 0, 0);
      chk("t4_run5", run_o, 1);
      step(0, 0, 0, 0, 0);
      chk("t4_idle_run", run_o, 0);
      chk("t4_idle_pulse", pulse_o, 0);
      chk("t4_idle_tick", tick_o, 0);
      chk("t4_cnt", per_cnt_o, (c0 + 1) % 4096);
      run1(); run1(); run1();
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("t4_drain4", run_o, 1);
      run1();
      chk("t4_ph5_run", run_o, 1);
      chk("t4_ph5_tick", tick_o, 0);
      run1();
      chk("t4_resume_tick", tick_o, 1);
      chk("t4_resume_cnt", per_cnt_o, (c0 + 2) % 4096);

      // 5: two writes before a boundary, last one wins
      step(0, 1, 1, 8, 3);
      step(0, 1, 1, 4, 1);
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         run1();
         if (tick_o === 1'b1) hit = 1;
      end
      if (!hit) timeout("t5_tick");
      n = 0;
      hi = (pulse_o === 1'b1) ? 1 : 0;
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         run1();
         n++;
         if (tick_o === 1'b1) hit = 1;
         else if (pulse_o === 1'b1) hi++;
      end
      if (!hit) timeout("t5_period");
      chk("t5_period", n, 4);
      chk("t5_high", hi, 1);

      // 6: reach 4095 periods, reset mid-period, then wrap to 0
      step(1, 0, 0, 0, 0);
      hit = 0;
      for (int i = 0; i < 9000 && !hit; i++) begin
         run1();
         if (m_cnt == 4095) hit = 1;
      end
      if (!hit) timeout("t6_reach");
      chk("t6_cnt_max", per_cnt_o, 4095);
      run1();
      step(1, 1, 1, 5, 2);
      chk("t6_rst_pulse", pulse_o, 0);
      chk("t6_rst_tick", tick_o, 0);
      chk("t6_rst_run", run_o, 0);
      chk("t6_rst_ack", cfg_ack, 0);
      chk("t6_rst_cnt", per_cnt_o, 0);
      hit = 0;
      for (int i = 0; i < 9000 && !hit; i++) begin
         run1();
         if (m_cnt == 4095) hit = 1;
      end
      if (!hit) timeout("t6_reach2");
      run1();
      run1();
      chk("t6_wrap", per_cnt_o, 0);
      chk("t6_wrap_tick", tick_o, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
